npc_unit: RTL and testbench
===========================

# npc_unit

Parametrised program-counter unit for the fetch stage. It owns the PC register and computes the next PC every cycle, choosing between these sources in fixed priority: trap vector, branch/jump redirect, stall hold, return-address-stack prediction, and sequential PC+4. It reports misaligned redirect targets back to the pipeline. It sits between the execute stage, which drives the redirect, and the instruction-memory address port.

## Interface
Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  hold PC (fetch back-pressure).
- trap  in  1  redirect to trap_vec.
- trap_vec  in  XLEN  trap target.
- br_taken  in  1  redirect to branch target.
- br_jalr  in  1  clear target bit 0 (JALR semantics).
- br_base  in  XLEN  target base (PC or rs1).
- br_offset  in  XLEN  target offset (immediate).
- ras_push  in  1  decode saw a call; push ras_push_addr.
- ras_push_addr  in  XLEN  return address to push.
- ras_pop  in  1  decode saw a return; predict from RAS top.
- pc  out  XLEN  current PC (registered).
- npc  out  XLEN  next PC (combinational).
- misaligned  out  1  registered one-cycle pulse: rejected redirect target.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.

## Operation
- Target: tgt = br_base + br_offset, modulo 2^XLEN; if br_jalr, then tgt[0] is forced to 0. tgt is misaligned when tgt[1]=1 (after the bit-0 clear).
- npc is selected in this priority, highest first:
  1. trap → trap_vec.
  2. br_taken and aligned → tgt.
  3. br_taken and misaligned → pc (hold), and misaligned=1 on the next cycle.
  4. stall → pc.
  5. ras_pop and not ras_empty → RAS top.
  6. otherwise → pc + 4, wrapping modulo 2^XLEN.
- Qualified cycle: stall=0, trap=0 and br_taken=0. ras_push and ras_pop take effect only in a qualified cycle; in any other cycle they are ignored.
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH).
  - Push only: write the entry at top+1, advance top, count increments and saturates at RAS_DEPTH. When full, the push overwrites the oldest entry.
  - Pop only, not empty: retreat top, count decrements.
  - Pop only, empty: no prediction and no state change.
  - Push and pop together, not empty: replace the top entry with ras_push_addr; count unchanged; the prediction uses the old top.
  - Push and pop together, empty: behaves as a push only.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH).

## Timing
- pc updates to npc on each rising clk edge. There is no latency between npc and the address presented for the next fetch.
- Reset values: pc=RESET_PC, misaligned=0, count=0, top=0, ras_empty=1, ras_full=0. RAS entry contents are don't-care.
- Reset has priority over all inputs, including in the middle of a redirect or push.
- misaligned is asserted for exactly one cycle, in the cycle after the offending br_taken. If br_taken with a misaligned target persists, the pulse repeats every cycle.
- trap together with a misaligned br_taken: the trap wins and misaligned is not raised.
- All inputs are sampled at the rising edge; there are no combinational paths from RAS state to anything except npc.

## Configuration
- NPC_RAS_EN defined: the RAS is implemented exactly as described above.
- NPC_RAS_EN undefined:
  - no RAS storage is built;
  - ras_push and ras_pop are ignored;
  - priority step 5 is removed;
  - ras_empty is tied to 1 and ras_full is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset and sequential: rst=1 for 2 cycles with RESET_PC=0x100, then idle → pc=0x100, then 0x104 and 0x108; pc at 0xFFFFFFFC wraps to 0x0.
- Redirect and priority: pc=0x200 with br_taken, br_base=0x200, br_offset=0xFFFFFFF0 → pc=0x1F0. Same cycle with stall=1 → still 0x1F0. trap=1 with trap_vec=0x80 plus br_taken → 0x80.
- JALR and misaligned:
  - br_jalr=1, base=0x301, offset=0 → pc=0x300, misaligned=0.
  - br_jalr=0, base=0x300, offset=2 → pc holds, misaligned=1 for exactly one cycle.
- RAS basic (NPC_RAS_EN): push 0x10, 0x20 → count=2. Pop → npc=0x20. Pop → 0x10, ras_empty=1. Third pop → npc=pc+4.
- RAS boundaries (RAS_DEPTH=4):
  - push 0x1..0x5 → ras_full=1; four pops yield 0x5, 0x4, 0x3, 0x2.
  - simultaneous push 0x99 and pop with top 0x40 → prediction 0x40, new top 0x99, count unchanged.
  - push during stall=1 → ignored.
- Build without NPC_RAS_EN: ras_pop=1 with prior pushes → npc=pc+4; ras_empty=1 throughout.

Source files
------------

// File: rtl/npc_unit.sv
// Fetch-stage program-counter unit: trap/branch/stall/RAS/sequential next-PC selection.
// Optional return-address stack built only when NPC_RAS_EN is defined.
module npc_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            br_taken,
    input  logic            br_jalr,
    input  logic [XLEN-1:0] br_base,
    input  logic [XLEN-1:0] br_offset,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);

    logic [XLEN-1:0] tgt_sum;
    logic [XLEN-1:0] tgt;
    logic            tgt_mis;
    logic            qualified;
    logic            pred_hit;
    logic [XLEN-1:0] pred_addr;

    assign tgt_sum   = br_base + br_offset;
    assign tgt       = {tgt_sum[XLEN-1:1], tgt_sum[0] & ~br_jalr};
    assign tgt_mis   = tgt[1];
    assign qualified = !stall && !trap && !br_taken;

`ifdef NPC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   top;
    logic [PW:0]     count;
    logic            do_push;
    logic            do_pop;
    logic            do_replace;

    assign ras_empty  = (count == '0);
    assign ras_full   = (count == DEPTH_CNT);
    assign pred_hit   = qualified && ras_pop && !ras_empty;
    assign pred_addr  = ras_mem[top];
    // A push paired with a pop on an empty stack degenerates into a plain push.
    assign do_push    = qualified && ras_push && !pred_hit;
    assign do_pop     = pred_hit && !ras_push;
    assign do_replace = pred_hit && ras_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            top   <= '0;
            count <= '0;
        end else if (do_push) begin
            top <= top + 1'b1;
            if (count != DEPTH_CNT)
                count <= count + 1'b1;
        end else if (do_pop) begin
            top   <= top - 1'b1;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            ras_mem[top + 1'b1] <= ras_push_addr;
        else if (!rst && do_replace)
            ras_mem[top] <= ras_push_addr;
    end
`else
    logic unused_ras;

    assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
    assign pred_hit   = 1'b0;
    assign pred_addr  = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

    always_comb begin
        npc = pc + XLEN'(4);
        if (trap)
            npc = trap_vec;
        else if (br_taken)
            npc = tgt_mis ? pc : tgt;
        else if (stall)
            npc = pc;
        else if (pred_hit)
            npc = pred_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            pc         <= npc;
            misaligned <= br_taken && tgt_mis && !trap;
        end
    end

endmodule

// File: tb/tb_npc_unit.sv
// Directed scoreboard bench for npc_unit; RAS section selected by NPC_RAS_EN.
module tb_npc_unit;

    logic        clk = 1'b0;
    logic        rst, stall, trap, br_taken, br_jalr, ras_push, ras_pop;
    logic [31:0] trap_vec, br_base, br_offset, ras_push_addr;
    logic [31:0] pc, npc;
    logic        misaligned, ras_empty, ras_full;

    npc_unit #(.XLEN(32), .RESET_PC(32'h100), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .trap_vec(trap_vec),
        .br_taken(br_taken), .br_jalr(br_jalr), .br_base(br_base), .br_offset(br_offset),
        .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
        .pc(pc), .npc(npc), .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
        logic        emp;
        logic        full;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] mpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] epc, input logic emis,
                        input logic eemp, input logic efull);
        exp_t e;
        sbq.push_back('{pc: epc, mis: emis, emp: eemp, full: efull, tag: tag});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.tag, ".pc"}, pc, e.pc);
        chk({e.tag, ".mis"}, {31'd0, misaligned}, {31'd0, e.mis});
        chk({e.tag, ".empty"}, {31'd0, ras_empty}, {31'd0, e.emp});
        chk({e.tag, ".full"}, {31'd0, ras_full}, {31'd0, e.full});
        mpc = e.pc;
        stall = 0; trap = 0; br_taken = 0; br_jalr = 0; ras_push = 0; ras_pop = 0;
    endtask

    task automatic branch(input logic jalr, input logic [31:0] base, input logic [31:0] off);
        br_taken = 1; br_jalr = jalr; br_base = base; br_offset = off;
    endtask

    initial begin
        rst = 1; stall = 0; trap = 0; br_taken = 0; br_jalr = 0; ras_push = 0; ras_pop = 0;
        trap_vec = 32'h80; br_base = 0; br_offset = 0; ras_push_addr = 0; mpc = 0;

        step("reset0", 32'h100, 0, 1, 0);
        step("reset1", 32'h100, 0, 1, 0);
        rst = 0;
        step("seq0", 32'h104, 0, 1, 0);
        step("seq1", 32'h108, 0, 1, 0);

        branch(0, 32'hFFFF_FFF0, 32'hC);
        step("to_top", 32'hFFFF_FFFC, 0, 1, 0);
        step("wrap", 32'h0, 0, 1, 0);

        branch(0, 32'h200, 32'h0);
        step("br200", 32'h200, 0, 1, 0);
        branch(0, 32'h200, 32'hFFFF_FFF0);
        step("br_neg", 32'h1F0, 0, 1, 0);
        branch(0, 32'h200, 32'hFFFF_FFF0); stall = 1;
        step("br_over_stall", 32'h1F0, 0, 1, 0);
        stall = 1;
        step("stall_hold", 32'h1F0, 0, 1, 0);
        branch(0, 32'h200, 32'hFFFF_FFF0); trap = 1;
        step("trap_over_br", 32'h80, 0, 1, 0);
        branch(0, 32'h302, 32'h0); trap = 1; trap_vec = 32'h90;
        step("trap_over_mis", 32'h90, 0, 1, 0);
        step("after_trap", 32'h94, 0, 1, 0);

        branch(1, 32'h301, 32'h0);
        step("jalr", 32'h300, 0, 1, 0);
        branch(0, 32'h300, 32'h2);
        #1 chk("mis_npc", npc, 32'h300);
        step("mis_hold", 32'h300, 1, 1, 0);
        step("mis_clear", 32'h304, 0, 1, 0);
        branch(0, 32'h300, 32'h2);
        step("mis_rep0", 32'h304, 1, 1, 0);
        branch(0, 32'h300, 32'h2);
        step("mis_rep1", 32'h304, 1, 1, 0);
        branch(1, 32'h303, 32'h0);
        step("jalr_mis", 32'h304, 1, 1, 0);
        step("jalr_mis_clr", 32'h308, 0, 1, 0);

        rst = 1; branch(0, 32'h302, 32'h0);
        step("rst_over_br", 32'h100, 0, 1, 0);
        rst = 0;

`ifdef NPC_RAS_EN
        ras_push = 1; ras_push_addr = 32'h10;
        step("push_pre", mpc + 4, 0, 0, 0);
        rst = 1; ras_push = 1; ras_push_addr = 32'h11;
        step("rst_over_push", 32'h100, 0, 1, 0);
        rst = 0;

        ras_push = 1; ras_push_addr = 32'h10;
        step("push10", mpc + 4, 0, 0, 0);
        ras_push = 1; ras_push_addr = 32'h20;
        step("push20", mpc + 4, 0, 0, 0);
        ras_pop = 1;
        #1 chk("pop20_npc", npc, 32'h20);
        step("pop20", 32'h20, 0, 0, 0);
        ras_pop = 1;
        #1 chk("pop10_npc", npc, 32'h10);
        step("pop10", 32'h10, 0, 1, 0);
        ras_pop = 1;
        #1 chk("pop_empty_npc", npc, 32'h14);
        step("pop_empty", 32'h14, 0, 1, 0);

        for (int i = 1; i <= 5; i++) begin
            ras_push = 1; ras_push_addr = 32'(i);
            step($sformatf("fill%0d", i), mpc + 4, 0, 0, i >= 4);
        end
        for (int i = 0; i < 4; i++) begin
            ras_pop = 1;
            #1 chk($sformatf("drain%0d_npc", i), npc, 32'(5 - i));
            step($sformatf("drain%0d", i), 32'(5 - i), 0, i == 3, 0);
        end

        ras_push = 1; ras_push_addr = 32'h40;
        step("push40", mpc + 4, 0, 0, 0);
        ras_push = 1; ras_push_addr = 32'h99; ras_pop = 1;
        #1 chk("swap_npc", npc, 32'h40);
        step("swap", 32'h40, 0, 0, 0);
        ras_pop = 1;
        #1 chk("swap_top_npc", npc, 32'h99);
        step("swap_top", 32'h99, 0, 1, 0);

        stall = 1; ras_push = 1; ras_push_addr = 32'h77;
        step("push_stalled", mpc, 0, 1, 0);
        ras_pop = 1;
        #1 chk("stalled_pop_npc", npc, mpc + 4);
        step("stalled_pop", mpc + 4, 0, 1, 0);
`else
        ras_push = 1; ras_push_addr = 32'h10;
        step("nr_push0", mpc + 4, 0, 1, 0);
        ras_push = 1; ras_push_addr = 32'h20;
        step("nr_push1", mpc + 4, 0, 1, 0);
        ras_pop = 1;
        #1 chk("nr_pop_npc", npc, mpc + 4);
        step("nr_pop", mpc + 4, 0, 1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
